// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake and HI/LO bus
// between control/datapath and the mul/div unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] writeData;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, operandA, operandB,
    output hiWrite, loWrite, writeData,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, operandA, operandB,
    input  hiWrite, loWrite, writeData,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit
// with architectural HI/LO registers.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic       clk,
  input logic       rst_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         op_q;
  logic               neg_a;
  logic               neg_b;
  logic               div0;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic idle_like;
  logic accept;
  logic last;
  logic sgn_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign idle_like = (state == IDLE) ||
                     (state == DONE);
  assign accept = idle_like & bus.start;
  assign last = (cnt == CNT_W'(WIDTH-1));
  assign sgn_in = ~bus.op[0];
  assign abs_a = (sgn_in & bus.operandA[WIDTH-1])
               ? -bus.operandA : bus.operandA;
  assign abs_b = (sgn_in & bus.operandB[WIDTH-1])
               ? -bus.operandB : bus.operandB;

  // One iteration of each datapath
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc[0] ? opb : '0)};
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1]
              - {1'b0, opb};
    if (div_trial[WIDTH])
      div_nxt = {acc[2*WIDTH-2:0], 1'b0};
    else
      div_nxt = {div_trial[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b1};
  end

  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    neg_res = neg_a ^ neg_b;
    prod = neg_res ? -acc : acc;
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    if (neg_res) quo = -quo;
    if (neg_a) rem = -rem;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      fix_hi = rem;
      fix_lo = quo;
      if (div0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: if (last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = bus.start ? CALC
                                  : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CALC) ||
               (state == FIX);
    bus.done = (state == DONE);
    bus.hi = hi_q;
    bus.lo = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      div0  <= 1'b0;
      a_raw <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        neg_a <= sgn_in & bus.operandA[WIDTH-1];
        neg_b <= sgn_in & bus.operandB[WIDTH-1];
        div0  <= bus.op[1] &
                 (bus.operandB == '0);
        a_raw <= bus.operandA;
        cnt   <= '0;
        if (bus.op[1]) begin
          acc <= {{WIDTH{1'b0}}, abs_a};
          opb <= abs_b;
        end else begin
          acc <= {{WIDTH{1'b0}}, abs_b};
          opb <= abs_a;
        end
      end else if (state == CALC) begin
        acc <= op_q[1] ? div_nxt : mul_nxt;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (idle_like && !bus.start) begin
        if (bus.hiWrite) hi_q <= bus.writeData;
        if (bus.loWrite) lo_q <= bus.writeData;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for
// muldiv_unit.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(
    .WIDTH(32),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.operandA = a;
    bus.operandB = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(
    output int cyc,
    output int bcnt
  );
    cyc = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operandA = '0;
    bus.operandB = '0;
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    bus.writeData = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      fails++;
      $display("FAIL reset busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_multu_latency;
    int cyc, bcnt;
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, bcnt);
    tests++;
    if (cyc !== 34 || bcnt !== 33) begin
      fails++;
      $display("FAIL latency done_cyc=%0d busy_cyc=%0d want 34 33",
               cyc, bcnt);
    end
    tests++;
    if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h1 ||
        bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL multu hi=%h lo=%h busy=%b want fffffffe 00000001 0",
               bus.hi, bus.lo, bus.busy);
    end
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse done=%b want 0", bus.done);
    end
  endtask

  task automatic test_arith;
    logic [1:0]  ops [8];
    logic [31:0] va  [8];
    logic [31:0] vb  [8];
    logic [31:0] ehi [8];
    logic [31:0] elo [8];
    int cyc, bcnt;
    ops[0]=2'b00; va[0]=32'hFFFFFFFD; vb[0]=32'd7;
    ehi[0]=32'hFFFFFFFF; elo[0]=32'hFFFFFFEB;
    ops[1]=2'b11; va[1]=32'd100; vb[1]=32'd7;
    ehi[1]=32'd2; elo[1]=32'd14;
    ops[2]=2'b10; va[2]=32'hFFFFFFF9; vb[2]=32'd2;
    ehi[2]=32'hFFFFFFFF; elo[2]=32'hFFFFFFFD;
    ops[3]=2'b10; va[3]=32'h12345678; vb[3]=32'd0;
    ehi[3]=32'h12345678; elo[3]=32'hFFFFFFFF;
    ops[4]=2'b10; va[4]=32'h80000000; vb[4]=32'hFFFFFFFF;
    ehi[4]=32'h0; elo[4]=32'h80000000;
    ops[5]=2'b10; va[5]=32'hFFFFFFF9; vb[5]=32'd0;
    ehi[5]=32'hFFFFFFF9; elo[5]=32'hFFFFFFFF;
    ops[6]=2'b00; va[6]=32'h80000000; vb[6]=32'h80000000;
    ehi[6]=32'h40000000; elo[6]=32'h0;
    ops[7]=2'b10; va[7]=32'd7; vb[7]=32'hFFFFFFFE;
    ehi[7]=32'd1; elo[7]=32'hFFFFFFFD;
    for (int i = 0; i < 8; i++) begin
      launch(ops[i], va[i], vb[i]);
      wait_done(cyc, bcnt);
      tests++;
      if (cyc !== 34 || bus.hi !== ehi[i] ||
          bus.lo !== elo[i]) begin
        fails++;
        $display("FAIL arith%0d cyc=%0d hi=%h lo=%h want 34 %h %h",
                 i, cyc, bus.hi, bus.lo, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    launch(2'b01, 32'd3, 32'd5);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.operandA = 32'd7;
        bus.operandB = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    tests++;
    if (cyc !== 34 || bus.hi !== 32'h0 ||
        bus.lo !== 32'd15) begin
      fails++;
      $display("FAIL start_ignored cyc=%0d hi=%h lo=%h want 34 0 f",
               cyc, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    launch(2'b11, 32'd100, 32'd7);
    wait_done(cyc, bcnt);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.operandA = 32'd6;
    bus.operandB = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.hi !== 32'd2 ||
        bus.lo !== 32'd14) begin
      fails++;
      $display("FAIL b2b_accept busy=%b hi=%h lo=%h want 1 2 e",
               bus.busy, bus.hi, bus.lo);
    end
    wait_done(cyc, bcnt);
    tests++;
    if (cyc !== 34 || bcnt !== 33 ||
        bus.hi !== 32'h0 || bus.lo !== 32'd42) begin
      fails++;
      $display("FAIL b2b cyc=%0d busy=%0d hi=%h lo=%h want 34 33 0 2a",
               cyc, bcnt, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    launch(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1)
        pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL reset_abort active_cycles=%0d want 0", pulses);
    end
  endtask

  task automatic test_hilo_write;
    int cyc, bcnt;
    @(negedge clk);
    bus.hiWrite = 1'b1;
    bus.writeData = 32'hCAFEBABE;
    @(negedge clk);
    bus.hiWrite = 1'b0;
    tests++;
    if (bus.hi !== 32'hCAFEBABE || bus.lo !== 32'h0) begin
      fails++;
      $display("FAIL mthi hi=%h lo=%h want cafebabe 0",
               bus.hi, bus.lo);
    end
    bus.hiWrite = 1'b1;
    bus.loWrite = 1'b1;
    bus.writeData = 32'h55667788;
    @(negedge clk);
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    tests++;
    if (bus.hi !== 32'h55667788 || bus.lo !== 32'h55667788) begin
      fails++;
      $display("FAIL mthi_mtlo hi=%h lo=%h want 55667788 55667788",
               bus.hi, bus.lo);
    end
    launch(2'b01, 32'd2, 32'd3);
    @(negedge clk);
    bus.loWrite = 1'b1;
    bus.writeData = 32'hDEADBEEF;
    @(negedge clk);
    bus.loWrite = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.lo !== 32'h55667788 || bus.hi !== 32'h55667788) begin
      fails++;
      $display("FAIL mtlo_busy hi=%h lo=%h want 55667788 55667788",
               bus.hi, bus.lo);
    end
    wait_done(cyc, bcnt);
    tests++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      fails++;
      $display("FAIL mtlo_busy_res hi=%h lo=%h want 0 6",
               bus.hi, bus.lo);
    end
    @(negedge clk);
    bus.hiWrite = 1'b1;
    bus.writeData = 32'h12121212;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.operandA = 32'h10;
    bus.operandB = 32'h10;
    bus.writeData = 32'h0BADF00D;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hiWrite = 1'b0;
    tests++;
    if (bus.hi !== 32'h12121212 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL start_wins hi=%h busy=%b want 12121212 1",
               bus.hi, bus.busy);
    end
    wait_done(cyc, bcnt);
    tests++;
    if (cyc !== 34 || bus.hi !== 32'h0 ||
        bus.lo !== 32'h100) begin
      fails++;
      $display("FAIL start_wins_res cyc=%0d hi=%h lo=%h want 34 0 100",
               cyc, bus.hi, bus.lo);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_multu_latency();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_hilo_write();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit that consumes the two register-file read outputs (A and B operands) in the execute stage. It implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes. It exposes busy/done so the control unit can stall MFHI/MFLO and any new mul/div until the result is ready. Iterative radix-2 datapath: one bit per cycle, fixed latency for all ops.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active low
start  in  1  launch operation; sampled only when busy=0
op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
operandA  in  WIDTH  multiplicand / dividend (register-file A output)
operandB  in  WIDTH  multiplier / divisor (register-file B output)
hiWrite  in  1  MTHI: HI <= writeData
loWrite  in  1  MTLO: LO <= writeData
writeData  in  WIDTH  data for MTHI/MTLO
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO hold the new result

Behaviour:
- All state updates on posedge clk. Reset: while rst_n=0 at an edge -> state IDLE, hi=0, lo=0, busy=0, done=0, counter=0, working registers=0. Reset mid-operation aborts it; no done pulse.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1: latch op; for signed ops latch |operandA|, |operandB|, record sign flags; init accumulator, counter=0. Next state CALC. busy=1 from the following cycle.
- CALC: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1). MUL: shift-add on 2*WIDTH product. DIV: restoring shift-subtract on 2*WIDTH remainder/quotient. At counter=WIDTH-1 -> FIX.
- FIX (1 cycle, busy=1): apply sign, write hi/lo. MUL signed: negate 64-bit product if signs differ; hi=product[63:32], lo=product[31:0]. DIV: lo=quotient, hi=remainder; signed: quotient negated if signs differ, remainder takes dividend sign. -> DONE.
- DONE (1 cycle): done=1, busy=0. start accepted here exactly as in IDLE. Without start -> IDLE.
- Latency: done=1 in the cycle after the 33rd edge following the edge that sampled start. Back-to-back throughput: one op per 34 cycles.
- busy=1 in CALC and FIX only; done=1 in DONE only.
- start while busy=1: ignored, no effect on running op.
- Divide by zero (either DIV form): full latency; lo=32'hFFFFFFFF, hi=operandA (original, unsigned bits).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of abs/negate with WIDTH-bit wrap).
- |0x80000000| is treated as unsigned 0x80000000.
- hiWrite/loWrite: applied at the edge only when busy=0 and start=0; ignored otherwise. Both may be applied in the same cycle. Write is visible on hi/lo the next cycle.
- hi/lo hold their value between updates. In CALC they hold the previous result.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 1 for 33 cycles; done pulse at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Pulse start again at cycle 5 of a MULTU with different operands -> ignored; result and done timing unchanged. Assert start during DONE -> new op accepted with no IDLE gap.
- Assert rst_n=0 at cycle 10 of a DIV -> next edge busy=0, done=0, hi=lo=0; no done pulse afterwards.
- hiWrite with writeData=0xCAFEBABE while idle -> hi=0xCAFEBABE next cycle. Assert loWrite while busy -> lo unchanged. Assert hiWrite together with start -> start wins and hi is not written.
